mem_ctrl: RTL and testbench

Host-side controller that drives the single-port `mem` block (16 x 8, synchronous write, registered read). It accepts write/read requests on a valid/ready handshake and sequences `mem`'s wr/rd/addr/Datain pins. It captures `Dataout` and returns read data on a valid/ready response channel. It also provides a hardware clear sweep that zeroes every location. It sits between any bus master or test sequencer and `mem`, so `mem` itself is never driven directly.

---
 rtl/mem_ctrl_pkg.sv | 16 +
 rtl/mem_ctrl.sv | 119 +++++++++++
 tb/tb_mem_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and default sizes for the mem host controller and its bench.
package mem_ctrl_pkg;

  localparam int AW_DEF = 4;
  localparam int DW_DEF = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    CAP  = 3'd3,
    RSP  = 3'd4,
    CLR  = 3'd5
  } state_t;

endpackage

// File: rtl/mem_ctrl.sv
// Host-side sequencer for the single-port mem block: request/response
// handshakes on the host side, registered wr/rd/addr/din pins on the mem
// side, plus a hardware sweep that zeroes every location.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  input  logic          clr_start,
  output logic          clr_done,
  output logic          busy,
  output logic          mem_wr,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  state_t        r_state;
  logic [AW-1:0] r_cnt;

  // Handshake and status are decoded straight from the state; rst masks
  // ready so a master never sees a request accepted during reset.
  assign req_ready = (r_state == IDLE) && !rst;
  assign busy      = (r_state != IDLE);

  // Controller FSM: every mem pin and response output is registered here,
  // set up on the edge that enters the state which uses it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      mem_wr    <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      clr_done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments everywhere in this block, so every
      // right-hand side sees the pre-edge value regardless of statement order.
      clr_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (clr_start) begin
            // Sweep wins over a simultaneous request; the master keeps
            // holding its request and it is taken after the sweep.
            r_state  <= CLR;
            r_cnt    <= '0;
            mem_wr   <= 1'b1;
            mem_addr <= '0;
            mem_din  <= '0;
          end else if (req_valid) begin
            mem_addr <= req_addr;
            if (req_we) begin
              mem_wr  <= 1'b1;
              mem_din <= req_wdata;
              r_state <= WR;
            end else begin
              mem_rd  <= 1'b1;
              r_state <= RD;
            end
          end
        end
        WR: begin
          mem_wr  <= 1'b0;
          r_state <= IDLE;
        end
        RD: begin
          mem_rd  <= 1'b0;
          r_state <= CAP;
        end
        CAP: begin
          // mem_dout is valid this cycle because rd was sampled last edge.
          rsp_rdata <= mem_dout;
          rsp_valid <= 1'b1;
          r_state   <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        CLR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ADDR) begin
            // Last location written this cycle; mem_addr keeps its value.
            mem_wr   <= 1'b0;
            clr_done <= 1'b1;
            r_state  <= IDLE;
          end else begin
            mem_addr <= r_cnt + 1'b1;
          end
        end
        default: begin
          mem_wr  <= 1'b0;
          mem_rd  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a behavioural 16x8 mem attached to the
// mem_* pins and a shadow array as the read-data reference.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int AW = AW_DEF;
  localparam int DW = DW_DEF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          clr_start = 1'b0;
  logic          clr_done;
  logic          busy;
  logic          mem_wr;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  int checks = 0;
  int errors = 0;
  int viol   = 0;

  logic [DW-1:0] model [2**AW];
  logic [DW-1:0] mem_arr [2**AW];

  always #5 clk = ~clk;

  mem_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .clr_start (clr_start),
    .clr_done  (clr_done),
    .busy      (busy),
    .mem_wr    (mem_wr),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  // Behavioural mem: synchronous write, registered read.
  always @(posedge clk) begin
    if (mem_wr) mem_arr[mem_addr] <= mem_din;
    if (mem_rd) mem_dout <= mem_arr[mem_addr];
  end

  // wr and rd must never be asserted together.
  always @(negedge clk) begin
    if (mem_wr && mem_rd) viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and wait (bounded) for the accepting edge.
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    #1;
    n = 0;
    while (!req_ready && n < 40) begin
      tick();
      n++;
    end
    if (!req_ready) check("accept_timeout", 0, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    issue(1'b1, a, d);
    if (!(mem_wr === 1'b1 && mem_addr === a && mem_din === d))
      check("wr_pins", {mem_wr, 3'b0, mem_addr, mem_din}, {1'b1, 3'b0, a, d});
    tick();
    if (req_ready !== 1'b1) check("wr_ready_back", req_ready, 1);
    model[a] = d;
  endtask

  // Read with rsp_ready high; rsp_valid must appear 3 cycles after acceptance.
  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    int lat;
    rsp_ready = 1'b1;
    issue(1'b0, a, '0);
    lat = 1;
    while (!rsp_valid && lat < 12) begin
      tick();
      lat++;
    end
    check("rd_latency", lat, 3);
    check("rd_data", rsp_rdata, exp);
    tick();
    if (rsp_valid !== 1'b0 || busy !== 1'b0) check("rd_release", {rsp_valid, busy}, 0);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 2**AW; i++) model[i] = '0;

    // Power-on reset.
    tick();
    tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_pins", {mem_wr, mem_rd, mem_addr, mem_din}, 0);
    check("rst_rsp", {rsp_valid, rsp_rdata, clr_done}, 0);
    rst = 1'b0;
    #1;
    check("rst_ready_after", req_ready, 1);

    // Initial sweep to give the mem known contents (reference already zero).
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    cnt = 0;
    while (!clr_done && cnt < 40) begin
      tick();
      cnt++;
    end
    check("init_clr_len", cnt, 16);

    // Test 2: writes then reads.
    do_write(4'h1, 8'hAA);
    do_write(4'h2, 8'hBB);
    do_read(4'h1, 8'hAA);
    do_read(4'h2, 8'hBB);

    // Test 1: reset two cycles mid-read.
    rsp_ready = 1'b1;
    issue(1'b0, 4'h1, '0);
    check("mid_rd_pulse", mem_rd, 1);
    rst = 1'b1;
    tick();
    tick();
    check("mr_req_ready", req_ready, 0);
    check("mr_busy", busy, 0);
    check("mr_mem_pins", {mem_wr, mem_rd, mem_addr, mem_din}, 0);
    check("mr_rsp", {rsp_valid, rsp_rdata, clr_done}, 0);
    rst = 1'b0;
    #1;
    check("mr_ready_after", req_ready, 1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid || mem_rd || mem_wr) cnt++;
      tick();
    end
    check("mr_no_activity", cnt, 0);

    // Test 3: backpressure on a read of 0x2.
    rsp_ready = 1'b0;
    issue(1'b0, 4'h2, '0);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_rdata, 8'hBB);
      check("bp_ready_low", req_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_idle", {busy, req_ready, rsp_valid}, 3'b010);

    // Test 4: clr_start collides with a held write of 0x3=0x55.
    clr_start = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 4'h3;
    req_wdata = 8'h55;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("clr_pins", {mem_wr, 3'b0, mem_addr, mem_din}, {1'b1, 3'b0, 4'(i), 8'h00});
      if (req_ready !== 1'b0) check("clr_ready_low", req_ready, 0);
      tick();
    end
    check("clr_done_pulse", {clr_done, busy, req_ready, mem_wr}, 4'b1010);
    for (int i = 0; i < 2**AW; i++) model[i] = '0;
    tick();
    req_valid = 1'b0;
    check("held_wr", {clr_done, mem_wr, 3'b0, mem_addr, mem_din}, {1'b0, 1'b1, 3'b0, 4'h3, 8'h55});
    model[3] = 8'h55;
    tick();
    do_read(4'h1, 8'h00);
    do_read(4'h3, 8'h55);

    // Test 6: clr_start while a response is pending is ignored.
    rsp_ready = 1'b0;
    issue(1'b0, 4'h3, '0);
    tick();
    tick();
    check("rsp_state", rsp_valid, 1);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (mem_wr || clr_done) cnt++;
      tick();
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (mem_wr || clr_done) cnt++;
      tick();
    end
    check("ign_clr", cnt, 0);

    // Test 5: 200 random operations against the shadow model.
    for (int i = 0; i < 200; i++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      a = AW'($urandom_range(0, 2**AW - 1));
      d = DW'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) do_write(a, d);
      else do_read(a, model[a]);
    end

    check("excl_viol", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
